// File: rtl/soc_system_ogpu_raster_cmd_out.sv
// soc_system_ogpu_raster_cmd_out
//   Avalon-MM write-side PIO. The HPS pushes DATA_W-bit raster commands into a
//   small first-word-fall-through FIFO, which drains to the raster unit over a
//   valid/ready stream.
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   address/write/writedata Avalon-MM slave write side (no waitrequest)
//   read/readdata           Avalon-MM slave read side, 1-cycle registered read
//   out_data/out_valid      FIFO head towards the raster unit
//   out_ready               raster unit takes the head this cycle
//   irq                     drain interrupt (only with RASTER_CMD_IRQ_EN)
//
// Register map
//   0 W  push writedata[DATA_W-1:0]
//   1 R  {irq_pend, overflow, full, empty, count[3:0]}, zero-extended
//   2 W  bit0 clear overflow, bit1 flush FIFO, bit2 clear irq_pend
//   3 R  last_cmd (last word popped), zero-extended
//
// Build option
//   RASTER_CMD_IRQ_EN  adds the irq port and the irq_pend status bit.

module soc_system_ogpu_raster_cmd_out #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef RASTER_CMD_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic       irq_pend;
    logic       overflow;
    logic       full;
    logic       empty;
    logic [3:0] count;
  } status_t;

  // storage and state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] last_cmd_q, last_cmd_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              irq_pend_q;

  // decode
  logic    empty, full, pop, push_req, ctrl_wr, flush, ovf_clr;
  logic    push_ok, drop;
  status_t status;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign push_req = write && (address == 2'd0);
  assign ctrl_wr  = write && (address == 2'd2);
  assign flush    = ctrl_wr && writedata[1];
  assign ovf_clr  = ctrl_wr && writedata[0];

  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;

  // A full FIFO still takes a word when the head leaves the same cycle; the
  // write lands in the slot being vacated, since wr_ptr == rd_ptr when full.
  // A flush swallows any push without flagging it as an overflow.
  assign push_ok = push_req && !flush && (!full || pop);
  assign drop    = push_req && !flush && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_cmd_d = last_cmd_q;
    if (pop) last_cmd_d = out_data;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // A dropped push beats a same-cycle clear so no loss goes unreported.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

`ifdef RASTER_CMD_IRQ_EN
  logic irq_set, irq_clr, irq_pend_d;

  // Drained means the last queued word left with nothing arriving behind it.
  assign irq_set = pop && (count_q == (ADDR_W+1)'(1)) && !push_ok && !flush;
  assign irq_clr = ctrl_wr && writedata[2];

  always_comb begin
    irq_pend_d = irq_pend_q;
    if (irq_clr) irq_pend_d = 1'b0;
    if (irq_set) irq_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_pend_q <= 1'b0;
    else          irq_pend_q <= irq_pend_d;
  end

  assign irq = irq_pend_q;
`else
  assign irq_pend_q = 1'b0;
`endif

  // Status is built from pre-edge state, so a push in the same cycle as a
  // status read shows up only on the following read.
  always_comb begin
    status          = '0;
    status.irq_pend = irq_pend_q;
    status.overflow = overflow_q;
    status.full     = full;
    status.empty    = empty;
    status.count    = 4'(count_q);
  end

  always_comb begin
    readdata_d = '0;
    if (read) begin
      case (address)
        2'd1:    readdata_d = 32'(status);
        2'd3:    readdata_d = 32'(last_cmd_q);
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_cmd_q <= '0;
      readdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      last_cmd_q <= last_cmd_d;
      readdata_q <= readdata_d;
    end
  end

  // Storage is reset so out_data reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= writedata[DATA_W-1:0];
    end
  end

  assign readdata = readdata_q;

  // Upper write-data bits carry nothing; bit2 is meaningful only with irq.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_soc_system_ogpu_raster_cmd_out.sv
module tb_soc_system_ogpu_raster_cmd_out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef RASTER_CMD_IRQ_EN
  logic        irq;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  soc_system_ogpu_raster_cmd_out #(.DEPTH(8), .ADDR_W(3), .DATA_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RASTER_CMD_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one clock, then settle past the edge before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    address = 2'd0; write = 1'b1; writedata = {16'h0, d};
    step();
    write = 1'b0;
  endtask

  task automatic ctrl(input logic [31:0] d);
    address = 2'd2; write = 1'b1; writedata = d;
    step();
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    address = a; read = 1'b1;
    step();
    read = 1'b0;
    r = readdata;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; write = 1'b0; writedata = '0;
    read = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_data", {16'h0, out_data}, 32'h0);
    reset_n = 1'b1;
    step();
    rd(2'd1, v); chk("rst_status", v, 32'h10);

    // T1: push into empty is visible the next cycle
    push(16'h1234);
    chk("t1_valid", {31'h0, out_valid}, 32'h1);
    chk("t1_data", {16'h0, out_data}, 32'h1234);
    rd(2'd1, v); chk("t1_status", v, 32'h1);
    ctrl(32'h2);
    chk("t1_flush_valid", {31'h0, out_valid}, 32'h0);

    // T2: nine pushes into eight slots, ninth dropped
    for (int i = 0; i < 9; i++) push(16'(i));
    rd(2'd1, v); chk("t2_status", v, 32'h68);  // overflow|full|count=8
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_drain%0d", i), {16'h0, out_data}, 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("t2_empty", {31'h0, out_valid}, 32'h0);
    ctrl(32'h4);

    // T4: flush with three queued, head popped in the same cycle
    push(16'h0011); push(16'h0022); push(16'h0033);
    out_ready = 1'b1;
    ctrl(32'h2);
    out_ready = 1'b0;
    chk("t4_valid", {31'h0, out_valid}, 32'h0);
    rd(2'd1, v); chk("t4_status", v, 32'h50);  // overflow kept, empty, count 0
    rd(2'd3, v); chk("t4_last", v, 32'h11);
    ctrl(32'h1);
    rd(2'd1, v); chk("t4_ovf_clr", v, 32'h10);

    // T3: full FIFO, push alongside a pop; pointers wrap
    for (int i = 0; i < 8; i++) push(16'(16'h100 + i));
    out_ready = 1'b1;
    push(16'hAAAA);
    out_ready = 1'b0;
    rd(2'd1, v); chk("t3_status", v, 32'h28);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_drain%0d", i), {16'h0, out_data},
          (i < 7) ? 32'(16'h101 + i) : 32'h0000AAAA);
      step();
    end
    out_ready = 1'b0;
    ctrl(32'h4);
    rd(2'd3, v); chk("t3_last", v, 32'hAAAA);

    // T5: last_cmd readback, write-only and idle reads give 0
    push(16'hBEEF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    ctrl(32'h4);
    rd(2'd3, v); chk("t5_last", v, 32'h0000BEEF);
    rd(2'd0, v); chk("t5_addr0", v, 32'h0);
    rd(2'd2, v); chk("t5_addr2", v, 32'h0);
    step();
    chk("t5_idle", readdata, 32'h0);

    // out_ready while empty must not disturb anything
    out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    rd(2'd1, v); chk("empty_ready", v, 32'h10);
    rd(2'd3, v); chk("empty_ready_last", v, 32'hBEEF);

`ifdef RASTER_CMD_IRQ_EN
    // T6: drain interrupt, clear, and set-beats-clear
    push(16'h0055);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_irq", {31'h0, irq}, 32'h1);
    rd(2'd1, v); chk("t6_status", v, 32'h90);
    ctrl(32'h4);
    chk("t6_irq_clr", {31'h0, irq}, 32'h0);
    push(16'h0066);
    out_ready = 1'b1;
    ctrl(32'h4);
    out_ready = 1'b0;
    chk("t6_set_wins", {31'h0, irq}, 32'h1);
    ctrl(32'h2);
    ctrl(32'h4);
    chk("t6_flush_noirq", {31'h0, irq}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
